// File: rtl/let_cmd_parser.sv
// let_cmd_parser
//
// Parses framed commands from a byte stream:
//   0xAA, 0x55, CMD, LEN_H, LEN_L, LEN payload bytes, CHK
// where CHK = (CMD + LEN_H + LEN_L + sum of payload) mod 256.
//
// Handshake: usb_data_valid_in is a one-cycle strobe that qualifies
// usb_data_in. There is no backpressure, so every strobed byte is consumed on
// the edge that samples it. Every output strobe (payload_valid, frame_ok,
// frame_err) is registered. It appears exactly one clock after the input
// strobe that caused it and lasts one clock.
//
// Payload bytes are streamed before the checksum is known. A consumer should
// commit the streamed data only when frame_ok pulses.
//
// Optional feature: define LET_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES consecutive clocks without a strobe. The abort pulses
// frame_err and returns the parser to IDLE. Without the macro the parser
// waits indefinitely for the next byte.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   usb_data_in[7:0]    received byte
//   usb_data_valid_in   byte strobe
//   cmd_out[7:0]        command byte of the current/last frame
//   len_out[15:0]       payload length of the current/last frame
//   payload_data[7:0]   streamed payload byte
//   payload_valid       one-cycle strobe per payload byte
//   payload_index[15:0] 0-based index of payload_data
//   frame_ok            one-cycle pulse, frame complete and checksum matched
//   frame_err           one-cycle pulse, checksum mismatch, over-length or timeout
//   busy                parser is inside a frame (FSM not IDLE)
module let_cmd_parser #(
  parameter int unsigned MAX_LEN        = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  usb_data_in,
  input  logic        usb_data_valid_in,
  output logic [7:0]  cmd_out,
  output logic [15:0] len_out,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic [15:0] payload_index,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SOF2  = 3'd1,
    S_CMD   = 3'd2,
    S_LEN_H = 3'd3,
    S_LEN_L = 3'd4,
    S_DATA  = 3'd5,
    S_CHK   = 3'd6
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  chk_acc;
  logic [15:0] data_cnt;
  logic        timeout;
  logic        ok_set;
  logic        err_set;
  logic        pay_set;

  // Full length as seen while the LEN_L byte is on the input
  logic [15:0] len_full;
  logic        len_over;
  logic [7:0]  chk_sum;

  assign len_full = {len_out[15:8], usb_data_in};
  assign len_over = 32'(len_full) > MAX_LEN;
  assign chk_sum  = chk_acc + usb_data_in;
  assign busy     = (state != S_IDLE);

`ifdef LET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive silent clock inside a frame
  assign timeout = (state != S_IDLE) && !usb_data_valid_in &&
                   (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state == S_IDLE || usb_data_valid_in || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;

  // TIMEOUT_CYCLES only matters with the timeout feature. This empty block
  // keeps the parameter referenced in the default build.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_param_unused
  end
`endif

  // Next-state and strobe decode
  always_comb begin
    state_next = state;
    ok_set     = 1'b0;
    err_set    = 1'b0;
    pay_set    = 1'b0;
    if (timeout) begin
      state_next = S_IDLE;
      err_set    = 1'b1;
    end else if (usb_data_valid_in) begin
      case (state)
        S_IDLE: begin
          if (usb_data_in == 8'hAA) state_next = S_SOF2;
        end
        S_SOF2: begin
          if (usb_data_in == 8'h55)      state_next = S_CMD;
          else if (usb_data_in == 8'hAA) state_next = S_SOF2;
          else                           state_next = S_IDLE;
        end
        S_CMD:   state_next = S_LEN_H;
        S_LEN_H: state_next = S_LEN_L;
        S_LEN_L: begin
          if (len_full == 16'd0) begin
            state_next = S_CHK;
          end else if (len_over) begin
            state_next = S_IDLE;
            err_set    = 1'b1;
          end else begin
            state_next = S_DATA;
          end
        end
        S_DATA: begin
          pay_set = 1'b1;
          if (data_cnt == len_out - 16'd1) state_next = S_CHK;
        end
        S_CHK: begin
          state_next = S_IDLE;
          if (usb_data_in == chk_acc) ok_set  = 1'b1;
          else                        err_set = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: header latches, checksum accumulator, payload stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_out       <= 8'd0;
      len_out       <= 16'd0;
      payload_data  <= 8'd0;
      payload_index <= 16'd0;
      payload_valid <= 1'b0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
      chk_acc       <= 8'd0;
      data_cnt      <= 16'd0;
    end else begin
      payload_valid <= pay_set;
      frame_ok      <= ok_set;
      frame_err     <= err_set;
      if (usb_data_valid_in) begin
        case (state)
          S_CMD: begin
            cmd_out <= usb_data_in;
            chk_acc <= usb_data_in;
          end
          S_LEN_H: begin
            len_out[15:8] <= usb_data_in;
            chk_acc       <= chk_sum;
          end
          S_LEN_L: begin
            len_out[7:0] <= usb_data_in;
            chk_acc      <= chk_sum;
            data_cnt     <= 16'd0;
          end
          S_DATA: begin
            payload_data  <= usb_data_in;
            payload_index <= data_cnt;
            data_cnt      <= data_cnt + 16'd1;
            chk_acc       <= chk_sum;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_let_cmd_parser.sv
// Testbench for let_cmd_parser.
// Frames are built by the bench from the framing rules. The expected output
// events are pushed into exp_q, and an independent monitor pops and compares
// them whenever the DUT raises an output strobe.
module tb_let_cmd_parser;

  localparam int MAX_LEN = 16;
  localparam int TO      = 64;
  // Event layout: {err,ok,pay}, index, data, cmd, len, busy, strobe-in-previous-cycle
  localparam int EW      = 3 + 16 + 8 + 8 + 16 + 1 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  usb_data_in = 8'd0;
  logic        usb_data_valid_in = 1'b0;
  logic [7:0]  cmd_out;
  logic [15:0] len_out;
  logic [7:0]  payload_data;
  logic        payload_valid;
  logic [15:0] payload_index;
  logic        frame_ok;
  logic        frame_err;
  logic        busy;

  let_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .usb_data_in(usb_data_in), .usb_data_valid_in(usb_data_valid_in),
    .cmd_out(cmd_out), .len_out(len_out),
    .payload_data(payload_data), .payload_valid(payload_valid),
    .payload_index(payload_index),
    .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [7:0]    tx_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [7:0]    m_cmd = 8'd0;
  logic [15:0]   m_len = 16'd0;
  logic          strobe_d = 1'b0;

  always @(posedge clk) strobe_d <= usb_data_valid_in;

  function automatic logic [EW-1:0] ev(input logic [2:0] typ, input logic [15:0] idx,
                                       input logic [7:0] data, input logic b, input logic s);
    return {typ, idx, data, m_cmd, m_len, b, s};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    if (rst_n && (payload_valid || frame_ok || frame_err)) begin
      act = {frame_err, frame_ok, payload_valid,
             payload_valid ? payload_index : 16'd0,
             payload_valid ? payload_data  : 8'd0,
             cmd_out, len_out, busy, strobe_d};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event actual=%h required=none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL event actual=%h required=%h", act, exp);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic put(input logic [7:0] b);
    @(negedge clk);
    usb_data_in       = b;
    usb_data_valid_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      usb_data_valid_in = 1'b0;
    end
  endtask

  task automatic send_tx(input bit rand_gaps);
    int g;
    while (tx_q.size() > 0) begin
      put(tx_q.pop_front());
      if (rand_gaps) begin
        g = $urandom_range(0, 2);
        if (g > 0) idle(g);
      end
    end
  endtask

  // Reference model: builds one frame from the framing rules
  task automatic model_frame(input logic [7:0] cmd, input int len, input bit corrupt);
    int         sum;
    logic [7:0] b;
    logic [7:0] chk;
    m_cmd = cmd;
    m_len = 16'(len);
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'h55);
    tx_q.push_back(cmd);
    tx_q.push_back(8'(len >> 8));
    tx_q.push_back(8'(len));
    if (len > MAX_LEN) begin
      exp_q.push_back(ev(3'b100, 16'd0, 8'd0, 1'b0, 1'b1));
      return;
    end
    sum = cmd + (len >> 8) + (len % 256);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      tx_q.push_back(b);
      sum += b;
      exp_q.push_back(ev(3'b001, 16'(i), b, 1'b1, 1'b1));
    end
    chk = 8'(sum % 256);
    if (corrupt) chk = chk ^ 8'($urandom_range(1, 255));
    tx_q.push_back(chk);
    exp_q.push_back(ev(corrupt ? 3'b100 : 3'b010, 16'd0, 8'd0, 1'b0, 1'b1));
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] f34[11] = '{8'hAA, 8'h55, 8'hFE, 8'h00, 8'h05, 8'h01, 8'h03, 8'hE8, 8'h01, 8'hF4, 8'hE4};
  logic [7:0] p34[5]  = '{8'h01, 8'h03, 8'hE8, 8'h01, 8'hF4};

  initial begin
    int len;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_cmd", 32'(cmd_out), 0);
    check("rst_len", 32'(len_out), 0);
    check("rst_pdata", 32'(payload_data), 0);
    check("rst_pindex", 32'(payload_index), 0);
    check("rst_strobes", {29'd0, payload_valid, frame_ok, frame_err}, 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    // AA 55 FF 00 00 FF -> frame_ok, no payload
    m_cmd = 8'hFF; m_len = 16'd0;
    exp_q.push_back(ev(3'b010, 16'd0, 8'd0, 1'b0, 1'b1));
    foreach (f34[i]) if (i < 5) tx_q.push_back(i == 2 ? 8'hFF : f34[i]);
    tx_q[4] = 8'h00;
    tx_q.push_back(8'hFF);
    send_tx(1'b0);
    idle(2);

    // AA 55 0A 00 01 5A 65 -> one payload then frame_ok
    m_cmd = 8'h0A; m_len = 16'd1;
    exp_q.push_back(ev(3'b001, 16'd0, 8'h5A, 1'b1, 1'b1));
    exp_q.push_back(ev(3'b010, 16'd0, 8'd0, 1'b0, 1'b1));
    tx_q = '{8'hAA, 8'h55, 8'h0A, 8'h00, 8'h01, 8'h5A, 8'h65};
    send_tx(1'b1);
    idle(2);

    // five-byte payload, good and bad checksum
    for (int pass = 0; pass < 2; pass++) begin
      m_cmd = 8'hFE; m_len = 16'd5;
      foreach (p34[i]) exp_q.push_back(ev(3'b001, 16'(i), p34[i], 1'b1, 1'b1));
      exp_q.push_back(ev(pass == 0 ? 3'b010 : 3'b100, 16'd0, 8'd0, 1'b0, 1'b1));
      foreach (f34[i]) tx_q.push_back(f34[i]);
      if (pass == 1) tx_q[10] = 8'hE5;
      send_tx(1'b0);
      idle(1);
      check("busy_after_chk", 32'(busy), 0);
      check("len_held", 32'(len_out), 5);
    end

    // resync on repeated 0xAA
    m_cmd = 8'hFF; m_len = 16'd0;
    exp_q.push_back(ev(3'b010, 16'd0, 8'd0, 1'b0, 1'b1));
    tx_q = '{8'h12, 8'hAA, 8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF};
    send_tx(1'b0);
    idle(2);

    // silence inside a frame
    m_cmd = 8'h0A;
`ifdef LET_TIMEOUT_EN
    exp_q.push_back(ev(3'b100, 16'd0, 8'd0, 1'b0, 1'b0));
    tx_q = '{8'hAA, 8'h55, 8'h0A};
    send_tx(1'b0);
    idle(TO);
    check("busy_before_timeout", 32'(busy), 1);
    @(negedge clk);
    check("busy_after_timeout", 32'(busy), 0);
    m_len = 16'd1;
    exp_q.push_back(ev(3'b001, 16'd0, 8'h5A, 1'b1, 1'b1));
    exp_q.push_back(ev(3'b010, 16'd0, 8'd0, 1'b0, 1'b1));
    tx_q = '{8'hAA, 8'h55, 8'h0A, 8'h00, 8'h01, 8'h5A, 8'h65};
    send_tx(1'b0);
`else
    tx_q = '{8'hAA, 8'h55, 8'h0A};
    send_tx(1'b0);
    idle(TO + 40);
    check("busy_no_timeout", 32'(busy), 1);
    m_len = 16'd1;
    exp_q.push_back(ev(3'b001, 16'd0, 8'h5A, 1'b1, 1'b1));
    exp_q.push_back(ev(3'b010, 16'd0, 8'd0, 1'b0, 1'b1));
    tx_q = '{8'h00, 8'h01, 8'h5A, 8'h65};
    send_tx(1'b0);
`endif
    idle(2);

    // length boundaries
    model_frame(8'h09, MAX_LEN, 1'b0);
    send_tx(1'b1);
    model_frame(8'h08, MAX_LEN + 1, 1'b0);
    send_tx(1'b1);
    model_frame(8'h07, 16'hFFFF, 1'b0);
    send_tx(1'b1);
    idle(2);

    // reset mid-frame: one payload byte streamed, then no end pulse
    m_cmd = 8'h07; m_len = 16'd3;
    exp_q.push_back(ev(3'b001, 16'd0, 8'h11, 1'b1, 1'b1));
    tx_q = '{8'hAA, 8'h55, 8'h07, 8'h00, 8'h03, 8'h11};
    send_tx(1'b0);
    idle(2);
    rst_n = 1'b0;
    idle(1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_cmd", 32'(cmd_out), 0);
    check("midrst_len", 32'(len_out), 0);
    check("midrst_pindex", 32'(payload_index), 0);
    rst_n = 1'b1;
    m_cmd = 8'd0; m_len = 16'd0;

    // randomized frames, noise between frames, back-to-back allowed
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) tx_q.push_back(8'($urandom_range(0, 8'hA9)));
      if ($urandom_range(0, 9) == 0) len = $urandom_range(MAX_LEN + 1, 65535);
      else                           len = $urandom_range(0, MAX_LEN);
      model_frame(8'($urandom), len, $urandom_range(0, 3) == 0);
      send_tx(1'b1);
    end
    idle(1);

    // drain with a bounded wait
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/let_cmd_parser.md
LET_CMD_PARSER -- requirements
Module: let_cmd_parser

Interface
REQ-001 Parameter MAX_LEN, default 1024: largest accepted payload length in bytes.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: idle clocks allowed between frame bytes (used only with LET_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 usb_data_in  input  8  received byte, sampled when usb_data_valid_in=1.
REQ-006 usb_data_valid_in  input  1  one-cycle byte strobe; no backpressure.
REQ-007 cmd_out  output  8  command byte of current/last frame.
REQ-008 len_out  output  16  payload length {LEN_H,LEN_L} of current/last frame.
REQ-009 payload_data  output  8  payload byte.
REQ-010 payload_valid  output  1  one-cycle strobe per payload byte.
REQ-011 payload_index  output  16  0-based index of payload_data.
REQ-012 frame_ok  output  1  one-cycle pulse: frame complete, checksum matched.
REQ-013 frame_err  output  1  one-cycle pulse: checksum mismatch, length over MAX_LEN, or timeout.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Frame format: 0xAA, 0x55, CMD, LEN_H, LEN_L, LEN payload bytes, CHK.
REQ-016 CHK = (CMD+LEN_H+LEN_L+sum of payload) mod 256, 8-bit wrapping accumulator.
REQ-017 FSM states: IDLE, SOF2, CMD, LEN_H, LEN_L, DATA, CHK; advance only on usb_data_valid_in.
REQ-018 IDLE: 0xAA -> SOF2; any other byte ignored.
REQ-019 SOF2: 0x55 -> CMD; 0xAA -> stay SOF2; other -> IDLE.
REQ-020 CMD: latch cmd_out, seed checksum; LEN_H, LEN_L: latch len_out, accumulate.
REQ-021 After LEN_L: LEN=0 -> CHK; LEN>MAX_LEN -> frame_err pulse, IDLE; else DATA.
REQ-022 DATA: each byte appears on payload_data/payload_valid/payload_index exactly one clock after its input strobe; after LEN bytes -> CHK.
REQ-023 CHK: one clock after the checksum byte strobe, pulse frame_ok (match) or frame_err (mismatch); return IDLE.
REQ-024 Payload is streamed unverified; consumers commit only on frame_ok.
REQ-025 Command value is not interpreted; any CMD (0x07,0x08,0x09,0x0A,0xFD,0xFE,0xFF, others) parsed identically.
REQ-026 cmd_out/len_out hold their values until the next frame's CMD/LEN bytes.
REQ-027 Back-to-back frames with zero idle clocks between them are accepted.

Reset
REQ-028 rst_n low: FSM->IDLE; cmd_out, len_out, payload_data, payload_index, checksum, timeout counter = 0; payload_valid, frame_ok, frame_err, busy = 0.
REQ-029 Reset mid-frame discards the frame with no frame_ok/frame_err pulse.

Configuration
REQ-030 Macro LET_TIMEOUT_EN defined: in any non-IDLE state, TIMEOUT_CYCLES consecutive clocks without usb_data_valid_in pulse frame_err and force IDLE; counter clears on each strobe.
REQ-031 LET_TIMEOUT_EN undefined: no timeout logic; FSM waits indefinitely for the next byte.

Verification
REQ-032 AA 55 FF 00 00 FF -> frame_ok once, cmd_out=0xFF, len_out=0, no payload_valid.
REQ-033 AA 55 0A 00 01 5A 65 -> payload_valid once, data 0x5A index 0, then frame_ok; cmd_out=0x0A.
REQ-034 AA 55 FE 00 05 01 03 E8 01 F4 E4 -> payloads 01,03,E8,01,F4 at indices 0-4, frame_ok, len_out=5.
REQ-035 Same frame with CHK=0xE5 -> frame_err once, no frame_ok, FSM back in IDLE (busy=0).
REQ-036 12 AA AA 55 FF 00 00 FF -> frame_ok (resync on repeated 0xAA).
REQ-037 With LET_TIMEOUT_EN, TIMEOUT_CYCLES=64: AA 55 0A then 64 silent clocks -> frame_err, busy=0; following valid heartbeat frame -> frame_ok.
